// File: rtl/alu_pkg.sv
// Shared types for the ALU result stage: select codes, skid-buffer state and the stored entry.
package alu_pkg;

    localparam int unsigned ALU_WIDTH = 32;
    localparam int unsigned ALU_SELW  = 3;

    typedef enum logic [ALU_SELW-1:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_AND  = 3'd4,
        OP_NAND = 3'd5,
        OP_NOR  = 3'd6,
        OP_OR   = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] result;
        logic [ALU_SELW-1:0]  sel;
        logic                 zero;
        logic                 negative;
        logic                 carry;
        logic                 overflow;
    } entry_t;

    // Carry/overflow only carry meaning for arithmetic operations.
    function automatic logic arith_op(input logic [ALU_SELW-1:0] sel);
        return (sel == OP_ADD) || (sel == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status-flag generation for a freshly selected ALU result.
module alu_flag_gen
    import alu_pkg::*;
(
    input  logic [ALU_WIDTH-1:0] result,
    input  logic [ALU_SELW-1:0]  sel,
    input  logic                 carry,
    input  logic                 overflow,
    output entry_t               entry_c
);

    always_comb begin
        entry_c          = '0;
        entry_c.result   = result;
        entry_c.sel      = sel;
        entry_c.zero     = (result == '0);
        entry_c.negative = result[ALU_WIDTH-1];
        entry_c.carry    = carry & arith_op(sel);
        entry_c.overflow = overflow & arith_op(sel);
    end

endmodule

// File: rtl/alu_result_stage.sv
// Registered 2-entry skid-buffer output stage for the ALU result mux.
// Optional sticky overflow flag enabled by defining ALU_RESULT_STICKY_OVF_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned SELW  = ALU_SELW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [SELW-1:0]  in_sel,
    input  logic             in_carry,
    input  logic             in_overflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [SELW-1:0]  out_sel,
    output logic             out_zero,
    output logic             out_negative,
    output logic             out_carry,
    output logic             out_overflow
`ifdef ALU_RESULT_STICKY_OVF_EN
    ,
    input  logic             sticky_clear,
    output logic             sticky_ovf
`endif
);

    state_e state_q, state_d;
    entry_t head_q, head_d;
    entry_t tail_q, tail_d;
    entry_t new_entry_c;
    logic   push;
    logic   pop;

    alu_flag_gen u_flag_gen (
        .result   (in_result),
        .sel      (in_sel),
        .carry    (in_carry),
        .overflow (in_overflow),
        .entry_c  (new_entry_c)
    );

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Vacated slots are zeroed so out_* read 0 whenever out_valid is low.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    head_d  = new_entry_c;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    head_d = new_entry_c;
                end else if (push) begin
                    tail_d  = new_entry_c;
                    state_d = FULL;
                end else if (pop) begin
                    head_d  = '0;
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    state_d = ONE;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign out_result   = head_q.result;
    assign out_sel      = head_q.sel;
    assign out_zero     = head_q.zero;
    assign out_negative = head_q.negative;
    assign out_carry    = head_q.carry;
    assign out_overflow = head_q.overflow;

`ifdef ALU_RESULT_STICKY_OVF_EN
    logic sticky_q, sticky_d;

    // Clear takes priority over a same-cycle overflow pop.
    always_comb begin
        sticky_d = sticky_q;
        if (pop && head_q.overflow) begin
            sticky_d = 1'b1;
        end
        if (sticky_clear) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_q <= 1'b0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_ovf = sticky_q;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage.
module tb_alu_result_stage;
    import alu_pkg::*;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned SELW  = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [SELW-1:0]  in_sel;
    logic             in_carry;
    logic             in_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [SELW-1:0]  out_sel;
    logic             out_zero;
    logic             out_negative;
    logic             out_carry;
    logic             out_overflow;
`ifdef ALU_RESULT_STICKY_OVF_EN
    logic             sticky_clear;
    logic             sticky_ovf;
`endif

    int errors = 0;
    int checks = 0;

    alu_result_stage #(.WIDTH(WIDTH), .SELW(SELW)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_sel       (in_sel),
        .in_carry     (in_carry),
        .in_overflow  (in_overflow),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_sel      (out_sel),
        .out_zero     (out_zero),
        .out_negative (out_negative),
        .out_carry    (out_carry),
        .out_overflow (out_overflow)
`ifdef ALU_RESULT_STICKY_OVF_EN
        ,
        .sticky_clear (sticky_clear),
        .sticky_ovf   (sticky_ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] flags();
        return 32'({out_zero, out_negative, out_carry, out_overflow});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b1;
        in_valid    = 1'b1;
        in_result   = 32'h5;
        in_sel      = 3'(OP_ADD);
        in_carry    = 1'b0;
        in_overflow = 1'b0;
        out_ready   = 1'b0;
`ifdef ALU_RESULT_STICKY_OVF_EN
        sticky_clear = 1'b0;
`endif
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_result", out_result, 32'd0);
        check("rst_flags", flags(), 32'd0);

        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        check("post_rst_nothing_captured", 32'(out_valid), 32'd0);

        // Zero result with masked carry
        in_valid  = 1'b1;
        in_result = 32'h0;
        in_sel    = 3'(OP_AND);
        in_carry  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_carry = 1'b0;
        check("and0_valid", 32'(out_valid), 32'd1);
        check("and0_sel", 32'(out_sel), 32'd4);
        check("and0_flags_zcm", flags(), 32'b1000);
        tick();
        check("and0_popped", 32'(out_valid), 32'd0);

        // Negative result with live overflow on SUB
        in_valid    = 1'b1;
        in_result   = 32'h8000_0000;
        in_sel      = 3'(OP_SUB);
        in_overflow = 1'b1;
        tick();
        in_valid    = 1'b0;
        in_overflow = 1'b0;
        check("sub_result", out_result, 32'h8000_0000);
        check("sub_flags_no", flags(), 32'b0101);
        tick();
        check("sub_popped", 32'(out_valid), 32'd0);
        check("sub_popped_zeroed", out_result, 32'd0);
`ifdef ALU_RESULT_STICKY_OVF_EN
        check("sticky_set", 32'(sticky_ovf), 32'd1);
        sticky_clear = 1'b1;
        tick();
        sticky_clear = 1'b0;
        check("sticky_cleared", 32'(sticky_ovf), 32'd0);
`endif

        // Fill both entries with consumer stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'(OP_OR);
        in_result = 32'h1;
        tick();
        check("fill1_ready", 32'(in_ready), 32'd1);
        check("fill1_head", out_result, 32'h1);
        in_result = 32'h2;
        tick();
        check("fill2_full", 32'(in_ready), 32'd0);
        in_result = 32'h3;
        tick();
        check("full_hold_head", out_result, 32'h1);
        check("full_hold_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("pop1_next", out_result, 32'h2);
        check("pop1_ready_back", 32'(in_ready), 32'd1);
        tick();
        check("pop2_empty", 32'(out_valid), 32'd0);

        // Streaming push and pop every cycle
        out_ready = 1'b1;
        in_carry  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid  = 1'b1;
            in_result = 32'h1 << i;
            in_sel    = 3'(i);
            tick();
            check("stream_result", out_result, 32'h1 << i);
            check("stream_sel", 32'(out_sel), 32'(i));
            check("stream_carry", 32'(out_carry), 32'(i < 2));
            check("stream_ready", 32'({out_valid, in_ready}), 32'b11);
        end
        in_valid = 1'b0;
        in_carry = 1'b0;
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);

        // Async reset while both entries are held
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_sel    = 3'(OP_XOR);
        in_result = 32'hA;
        tick();
        in_result = 32'hB;
        tick();
        in_valid = 1'b0;
        check("pre_rst_full", 32'(in_ready), 32'd0);
        check("pre_rst_head", out_result, 32'hA);
        #3;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_result", out_result, 32'd0);
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_result = 32'h3;
        tick();
        in_valid = 1'b0;
        check("after_rst_result", out_result, 32'h3);
        check("after_rst_valid", 32'(out_valid), 32'd1);
        tick();
        check("after_rst_alone", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
